// File: rtl/linebuffer_feeder_if.sv
// Handshake and memory bus between the line-buffer feeder, image RAM, start control and line buffer.
interface linebuffer_feeder_if #(
  parameter int BIT_DEPTH = 8,
  parameter int ADDR_W    = 10
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 band_done;
  logic                 sink_ready;
  logic                 mem_rd_en;
  logic [ADDR_W-1:0]    mem_addr;
  logic [BIT_DEPTH-1:0] mem_rdata;
  logic                 lb_wr_en;
  logic [BIT_DEPTH-1:0] lb_data_r1;
  logic [BIT_DEPTH-1:0] lb_data_r2;
  logic [BIT_DEPTH-1:0] lb_data_r3;

  modport master (
    input  start, sink_ready, mem_rdata,
    output busy, done, band_done, mem_rd_en, mem_addr,
           lb_wr_en, lb_data_r1, lb_data_r2, lb_data_r3
  );

  modport slave (
    output start, sink_ready, mem_rdata,
    input  busy, done, band_done, mem_rd_en, mem_addr,
           lb_wr_en, lb_data_r1, lb_data_r2, lb_data_r3
  );
endinterface

// File: rtl/linebuffer_feeder.sv
// Fetches 3-row bands column by column from a row-major image RAM into the line buffer.
// Build option LINEBUFFER_FEEDER_ZERO_PAD_EN adds one zero row above and below the image.
module linebuffer_feeder #(
  parameter int BIT_DEPTH = 8,
  parameter int COLS      = 28,
  parameter int ROWS      = 28,
  parameter int ADDR_W    = 10
) (
  input logic                 clk,
  input logic                 rst_n,
  linebuffer_feeder_if.master bus
);

`ifdef LINEBUFFER_FEEDER_ZERO_PAD_EN
  localparam int NBANDS  = ROWS;
  localparam int ROW_OFF = 1;
`else
  localparam int NBANDS  = ROWS - 2;
  localparam int ROW_OFF = 0;
`endif
  localparam int CW = $clog2(COLS + 1);
  localparam int BW = $clog2(NBANDS + 1);

  // IDLE wait start | RD0-RD2 read top/mid/bot | CAP capture bot | PUSH strobe when sink ready
  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, CAP, PUSH} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [BW-1:0]        band_q, band_d;
  logic [BIT_DEPTH-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  logic                 done_q, done_d;
  logic                 band_done_q, band_done_d;
  logic                 rd_vld_q;
  logic                 rd_en, wr_en;
  logic [ADDR_W-1:0]    addr;
  logic [BIT_DEPTH-1:0] cap;
  int                   slot;
  int                   row;

  // A skipped (padded) read slot captures zero instead of stale RAM data.
  assign cap = rd_vld_q ? bus.mem_rdata : '0;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    band_d      = band_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    r3_d        = r3_q;
    done_d      = 1'b0;
    band_done_d = 1'b0;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    slot        = 0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RD0;
          col_d   = '0;
          band_d  = '0;
        end
      end
      RD0: begin
        slot    = 0;
        rd_en   = 1'b1;
        state_d = RD1;
      end
      RD1: begin
        slot    = 1;
        rd_en   = 1'b1;
        r1_d    = cap;
        state_d = RD2;
      end
      RD2: begin
        slot    = 2;
        rd_en   = 1'b1;
        r2_d    = cap;
        state_d = CAP;
      end
      CAP: begin
        r3_d    = cap;
        state_d = PUSH;
      end
      PUSH: begin
        if (bus.sink_ready) begin
          wr_en   = 1'b1;
          state_d = RD0;
          if (col_q == CW'(COLS - 1)) begin
            col_d       = '0;
            band_done_d = 1'b1;
            if (band_q == BW'(NBANDS - 1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
              band_d  = '0;
            end else begin
              band_d = band_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    row = int'(band_q) + slot - ROW_OFF;
    if (row < 0 || row >= ROWS) rd_en = 1'b0;
    addr = rd_en ? ADDR_W'(row * COLS + int'(col_q)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      band_q      <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      r3_q        <= '0;
      done_q      <= 1'b0;
      band_done_q <= 1'b0;
      rd_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      band_q      <= band_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      r3_q        <= r3_d;
      done_q      <= done_d;
      band_done_q <= band_done_d;
      rd_vld_q    <= rd_en;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.band_done  = band_done_q;
  assign bus.mem_rd_en  = rd_en;
  assign bus.mem_addr   = addr;
  assign bus.lb_wr_en   = wr_en;
  assign bus.lb_data_r1 = r1_q;
  assign bus.lb_data_r2 = r2_q;
  assign bus.lb_data_r3 = r3_q;

endmodule

// File: tb/tb_linebuffer_feeder.sv
// Bench for linebuffer_feeder: directed frames plus randomized RAM/back-pressure against a frame model.
module tb_linebuffer_feeder;
  localparam int BIT_DEPTH = 8;
  localparam int COLS      = 3;
  localparam int ROWS      = 4;
  localparam int ADDR_W    = 10;
`ifdef LINEBUFFER_FEEDER_ZERO_PAD_EN
  localparam int PADI = 1;
`else
  localparam int PADI = 0;
`endif
  localparam int NB     = (PADI == 1) ? ROWS : ROWS - 2;
  localparam int NPUSH  = NB * COLS;
  localparam int LOGN   = 512;
  localparam int SPEC_DONE = (PADI == 1) ? 61 : 31;
  localparam logic [23:0] SPEC_FIRST = (PADI == 1) ? 24'h000003 : 24'h000306;
  localparam logic [23:0] SPEC_LAST  = (PADI == 1) ? 24'h080B00 : 24'h05080B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  linebuffer_feeder_if #(.BIT_DEPTH(BIT_DEPTH), .ADDR_W(ADDR_W)) bus();

  linebuffer_feeder #(
    .BIT_DEPTH(BIT_DEPTH), .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [7:0] ram [ROWS*COLS];
  always @(posedge clk)
    if (bus.mem_rd_en) bus.mem_rdata <= ram[int'(bus.mem_addr) % (ROWS*COLS)];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  bit mon_en = 1'b0;

  logic        wr_log[LOGN], bd_log[LOGN], dn_log[LOGN], busy_log[LOGN], rd_log[LOGN];
  logic [23:0] dat_log[LOGN];
  bit          sr_pat[LOGN];

  int          exp_t[NPUSH], exp_e[NPUSH], exp_bd[NB];
  logic [23:0] exp_d[NPUSH];
  int          exp_done, exp_rd;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int r;
    r = cyc - t0;
    if (mon_en && r >= 0 && r < LOGN) begin
      wr_log[r]   = bus.lb_wr_en;
      bd_log[r]   = bus.band_done;
      dn_log[r]   = bus.done;
      busy_log[r] = bus.busy;
      rd_log[r]   = bus.mem_rd_en;
      dat_log[r]  = {bus.lb_data_r1, bus.lb_data_r2, bus.lb_data_r3};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_sr(input int lo, input int hi, input bit rnd);
    for (int i = 0; i < LOGN; i++)
      sr_pat[i] = (rnd && i < 400) ? ($urandom_range(0, 3) != 0) : !(i >= lo && i <= hi);
  endtask

  // Expected frame from the band/column walk: 4 cycles of reads+capture, then a push
  // that waits for sink_ready, next column starting the cycle after.
  task automatic model_frame();
    int tc;
    int i;
    int y;
    logic [7:0] v[3];
    tc = 1;
    i = 0;
    exp_rd = 0;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < COLS; c++) begin
        for (int k = 0; k < 3; k++) begin
          y = b - PADI + k;
          if (y < 0 || y >= ROWS) v[k] = 8'h00;
          else begin
            v[k] = ram[y*COLS + c];
            exp_rd++;
          end
        end
        exp_d[i] = {v[0], v[1], v[2]};
        exp_e[i] = tc + 4;
        exp_t[i] = tc + 4;
        while (exp_t[i] < LOGN - 1 && !sr_pat[exp_t[i]]) exp_t[i]++;
        tc = exp_t[i] + 1;
        if (c == COLS - 1) exp_bd[b] = tc;
        i++;
      end
    end
    exp_done = tc;
  endtask

  task automatic run_frame(input int start2, input int rst_at, input int ncyc);
    for (int i = 0; i < LOGN; i++) begin
      wr_log[i] = 0; bd_log[i] = 0; dn_log[i] = 0; busy_log[i] = 0; rd_log[i] = 0;
      dat_log[i] = '0;
    end
    t0 = cyc;
    mon_en = 1'b1;
    for (int r = 0; r < ncyc; r++) begin
      bus.start = (r == 0) || (r == start2);
      bus.sink_ready = sr_pat[r];
      if (r == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", 32'({bus.busy, bus.done, bus.band_done, bus.mem_rd_en, bus.lb_wr_en}), 0);
        chk("rst_mid_addr", 32'(bus.mem_addr), 0);
        chk("rst_mid_data", 32'({bus.lb_data_r1, bus.lb_data_r2, bus.lb_data_r3}), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_idle", 32'({bus.busy, bus.mem_rd_en, bus.lb_wr_en}), 0);
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.sink_ready = 1'b1;
    mon_en = 1'b0;
  endtask

  task automatic check_frame();
    int nwr, nbd, ndn, nbusy, nrd, bad;
    nwr = 0; nbd = 0; ndn = 0; nbusy = 0; nrd = 0; bad = 0;
    for (int r = 0; r < LOGN; r++) begin
      nwr += int'(wr_log[r]);
      nbd += int'(bd_log[r]);
      ndn += int'(dn_log[r]);
      nbusy += int'(busy_log[r]);
      nrd += int'(rd_log[r]);
    end
    chk("busy_c0", 32'(busy_log[0]), 0);
    chk("busy_c1", 32'(busy_log[1]), 1);
    chk("wr_count", nwr, NPUSH);
    for (int i = 0; i < NPUSH; i++) begin
      chk("push_t", 32'(wr_log[exp_t[i]]), 1);
      chk("push_d", 32'(dat_log[exp_t[i]]), 32'(exp_d[i]));
      for (int s = exp_e[i]; s <= exp_t[i]; s++)
        if (dat_log[s] !== exp_d[i]) bad++;
    end
    chk("stall_hold", bad, 0);
    chk("bd_count", nbd, NB);
    for (int b = 0; b < NB; b++) chk("bd_t", 32'(bd_log[exp_bd[b]]), 1);
    chk("done_count", ndn, 1);
    chk("done_t", 32'(dn_log[exp_done]), 1);
    chk("busy_end", 32'(busy_log[exp_done]), 0);
    chk("busy_len", nbusy, exp_done - 1);
    chk("rd_count", nrd, exp_rd);
  endtask

  // Frame-level numbers straight from the reference scenarios (RAM holds its address).
  task automatic spec_checks(input int first_t, input int done_t);
    int fw, lw, dn;
    fw = -1; lw = -1; dn = -1;
    for (int r = 0; r < LOGN; r++) begin
      if (wr_log[r] && fw < 0) fw = r;
      if (wr_log[r]) lw = r;
      if (dn_log[r] && dn < 0) dn = r;
    end
    chk("spec_first_t", fw, first_t);
    chk("spec_first_d", (fw >= 0) ? 32'(dat_log[fw]) : 32'hFFFF_FFFF, 32'(SPEC_FIRST));
    chk("spec_last_d", (lw >= 0) ? 32'(dat_log[lw]) : 32'hFFFF_FFFF, 32'(SPEC_LAST));
    chk("spec_done_t", dn, done_t);
    chk("spec_rd_total", exp_rd, (PADI == 1) ? 30 : 18);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.sink_ready = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < ROWS*COLS; i++) ram[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 32'({bus.busy, bus.done, bus.band_done, bus.mem_rd_en, bus.lb_wr_en}), 0);
    chk("reset_addr", 32'(bus.mem_addr), 0);
    chk("reset_data", 32'({bus.lb_data_r1, bus.lb_data_r2, bus.lb_data_r3}), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    fill_sr(-1, -1, 1'b0);
    model_frame();
    run_frame(-1, -1, exp_done + 3);
    check_frame();
    spec_checks(5, SPEC_DONE);

    fill_sr(5, 7, 1'b0);
    model_frame();
    run_frame(-1, -1, exp_done + 3);
    check_frame();
    spec_checks(8, SPEC_DONE + 3);
    chk("bp_hold_c5", 32'(dat_log[5]), 32'(SPEC_FIRST));
    chk("bp_hold_c7", 32'(dat_log[7]), 32'(SPEC_FIRST));

    fill_sr(-1, -1, 1'b0);
    model_frame();
    run_frame(12, -1, exp_done + 3);
    check_frame();
    spec_checks(5, SPEC_DONE);

    run_frame(-1, 13, 40);
    @(posedge clk);
    #1;
    model_frame();
    run_frame(-1, -1, exp_done + 3);
    check_frame();
    spec_checks(5, SPEC_DONE);

    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < ROWS*COLS; i++) ram[i] = 8'($urandom);
      fill_sr(-1, -1, 1'b1);
      model_frame();
      run_frame(-1, -1, exp_done + 3);
      check_frame();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/linebuffer_feeder.md
# linebuffer_feeder

- Fetch engine that fills the three-row line buffer from a row-major image RAM.
- For each band of three vertically adjacent image rows, it reads one column at a time: three single-port RAM reads per column.
- It then pushes the three pixels into the line buffer's row inputs with a one-cycle write strobe.
- It walks all COLS columns, advances the band by one row, and repeats until the image is exhausted. It sits between image memory and the line buffer / convolution window in the NPU datapath.

## Interface

- BIT_DEPTH, 8, pixel width
- COLS, 28, image width (columns per band)
- ROWS, 28, image height (≥3)
- ADDR_W, 10, RAM address width; must satisfy 2^ADDR_W ≥ ROWS*COLS

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last push
- band_done  out  1  one-cycle pulse in the cycle after the last column push of each band
- sink_ready  in  1  consumer allows a push this cycle
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  ADDR_W  RAM read address
- mem_rdata  in  BIT_DEPTH  RAM data, valid the cycle after mem_rd_en
- lb_wr_en  out  1  line-buffer write/shift strobe, one cycle per column
- lb_data_r1/r2/r3  out  BIT_DEPTH each  pixels from band rows top, middle, bottom

## Operation

- FSM states: IDLE, RD0, RD1, RD2, CAP, PUSH.
  - IDLE: start=1 → RD0; col=0, band=0.
  - RD0: issue row_top address; RD1: issue row_mid address, capture mem_rdata → r1.
  - RD2: issue row_bot address, capture → r2; CAP: capture → r3.
  - PUSH: if sink_ready, assert lb_wr_en; otherwise hold lb_wr_en=0 and lb_data stable.
  - PUSH with sink_ready, col<COLS-1: col+1 → RD0.
  - PUSH with sink_ready, col=COLS-1, not last band: col=0, band+1, band_done next cycle → RD0.
  - PUSH with sink_ready, last band: → IDLE with done pulse.
- Address rule: the address for image row y and column c is y*COLS+c, computed in ADDR_W bits with no wrap. Band b covers rows b+k, k=0..2.
- Band count without padding: ROWS-2 (b = 0..ROWS-3).
- Reset values: all outputs 0; FSM IDLE; counters 0.
- start while busy is ignored.
- rst_n asserted mid-frame immediately forces IDLE and all outputs 0; no partial push completes. A new frame requires a fresh start.
- Capture registers (lb_data_*) change only in RD1/RD2/CAP. They hold during the PUSH stall.

## Timing

- Start accepted at edge ending cycle 0. RD0 is cycle 1, so busy=1 and mem_rd_en=1 from cycle 1.
- Column period is 5 cycles with sink_ready held high. The first lb_wr_en is in cycle 5.
- Each cycle sink_ready is low in PUSH adds exactly one cycle.
- mem_rd_en is high only in RD0/RD1/RD2. It is 1 for exactly three cycles per column (fewer for padded rows, see below).
- A frame with N bands and no stall takes N*COLS*5 cycles of busy. done and busy=0 occur in the cycle after the last lb_wr_en.
- band_done and done coincide for the final band.

## Configuration

- Macro: LINEBUFFER_FEEDER_ZERO_PAD_EN.
- Defined:
  - Frame has ROWS bands; band b covers rows b-1..b+1.
  - Any row <0 or ≥ROWS is not read: mem_rd_en stays 0 in that slot, and 0 is captured into the corresponding lb_data register.
  - Slot timing (5 cycles/column) is unchanged.
- Undefined: ROWS-2 bands, no padding; all reads are issued.

## Test plan

- Setup for all scenarios: ROWS=4, COLS=3, RAM content = address; unpadded unless stated.
- Nominal frame: start in cycle 0, sink_ready=1.
  - Pushes (r1,r2,r3): (0,3,6), (1,4,7), (2,5,8), (3,6,9), (4,7,10), (5,8,11).
  - lb_wr_en in cycles 5, 10, …, 30.
  - band_done in cycles 16 and 31; done in cycle 31; busy low from cycle 31.
- Back-pressure: sink_ready=0 in cycles 5–7.
  - First push occurs in cycle 8 with (0,3,6); lb_data is stable during cycles 5–7.
  - Every later event is shifted by +3 cycles.
- Start while busy: pulse start in cycle 12. Push sequence and done timing are identical to the nominal frame.
- Reset mid-frame: drop rst_n in cycle 13 for 2 cycles.
  - All outputs read 0 asynchronously; the FSM is in IDLE.
  - A new start reproduces the nominal sequence from (0,3,6).
- With LINEBUFFER_FEEDER_ZERO_PAD_EN defined: 12 pushes.
  - First push is (0,0,3) and the last is (8,11,0).
  - mem_rd_en count is 30.
  - done is in cycle 61.
